// File: rtl/osd_mam_wb_sram_if.sv
// Wishbone classic single-beat bus between the MAM master and the scratch SRAM.
// Signal names keep the slave-side port names of the original memory.
interface osd_mam_wb_sram_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned SW = DATA_WIDTH / 8;

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SW-1:0]         sel_i;
  logic [2:0]            cti_i;
  logic [1:0]            bte_i;
  logic                  ack_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] dat_o;

  modport master (
    output cyc_i, stb_i, we_i, addr_i, dat_i, sel_i, cti_i, bte_i,
    input  ack_o, err_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, dat_i, sel_i, cti_i, bte_i,
    output ack_o, err_o, dat_o
  );
endinterface

// File: rtl/osd_mam_wb_sram.sv
// Wishbone classic slave scratch memory with byte enables and a configurable
// number of wait states between request acceptance and the ack/err pulse.
module osd_mam_wb_sram #(
  parameter int unsigned          DATA_WIDTH  = 16,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned          WAIT_STATES = 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  osd_mam_wb_sram_if.slave  bus
);
  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned LSB  = $clog2(SW);
  localparam int unsigned IDXW = $clog2(MEM_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  req, go_resp;
  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range, aligned, bad_live;
  logic [IDXW-1:0]       idx_live;

  logic                  lat_we, lat_bad;
  logic [IDXW-1:0]       lat_idx;
  logic [DATA_WIDTH-1:0] lat_dat;
  logic [SW-1:0]         lat_sel;

  logic                  cur_we, cur_bad;
  logic [IDXW-1:0]       cur_idx;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic [SW-1:0]         cur_sel;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                  unused_bus;

  assign unused_bus = ^{bus.cti_i, bus.bte_i};

  assign req      = bus.cyc_i & bus.stb_i;
  assign off      = bus.addr_i - BASE_ADDR;
  assign in_range = (off >> (LSB + IDXW)) == '0;
  assign aligned  = (off & ADDR_WIDTH'(SW - 1)) == '0;
  assign idx_live = IDXW'(off >> LSB);
  assign bad_live = !in_range || !aligned;

  // With zero wait states the response is produced straight from IDLE, so
  // the live decode is used there and the latched copy everywhere else.
  always_comb begin
    cur_we  = lat_we;
    cur_bad = lat_bad;
    cur_idx = lat_idx;
    cur_dat = lat_dat;
    cur_sel = lat_sel;
    if (state == IDLE) begin
      cur_we  = bus.we_i;
      cur_bad = bad_live;
      cur_idx = idx_live;
      cur_dat = bus.dat_i;
      cur_sel = bus.sel_i;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    go_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = RESP;
          go_resp    = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bus.ack_o <= go_resp && !cur_bad;
      bus.err_o <= go_resp && cur_bad;
      bus.dat_o <= (go_resp && !cur_bad && !cur_we) ? mem[cur_idx] : '0;
      if (state == IDLE && req) begin
        lat_we  <= bus.we_i;
        lat_bad <= bad_live;
        lat_idx <= idx_live;
        lat_dat <= bus.dat_i;
        lat_sel <= bus.sel_i;
      end
    end
  end

  // The write commits on the edge that enters RESP; a coincident reset drops it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && go_resp && cur_we && !cur_bad) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// Bench for osd_mam_wb_sram: four instances with different wait states and
// base addresses, vector table, hand sequences and a randomized model check.
module tb_osd_mam_wb_sram;
  logic clk;
  logic [3:0]       rst_n, cyc, stb, we, ack, err;
  logic [3:0][31:0] addr;
  logic [3:0][15:0] wdat, rdat;
  logic [3:0][1:0]  sel, bte;
  logic [3:0][2:0]  cti;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned WS   = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
    localparam logic [31:0] BASE = (g >= 2) ? 32'h0000_8000 : 32'h0;
    osd_mam_wb_sram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();
    assign bus.cyc_i  = cyc[g];
    assign bus.stb_i  = stb[g];
    assign bus.we_i   = we[g];
    assign bus.addr_i = addr[g];
    assign bus.dat_i  = wdat[g];
    assign bus.sel_i  = sel[g];
    assign bus.cti_i  = cti[g];
    assign bus.bte_i  = bte[g];
    assign ack[g]     = bus.ack_o;
    assign err[g]     = bus.err_o;
    assign rdat[g]    = bus.dat_o;
    osd_mam_wb_sram #(
      .DATA_WIDTH(16), .ADDR_WIDTH(32), .MEM_WORDS(1024),
      .BASE_ADDR(BASE), .WAIT_STATES(WS)
    ) dut (
      .clk_i(clk), .rst_ni(rst_n[g]), .bus(bus.slave)
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 5;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k >= 2) ? 32'h0000_8000 : 32'h0;
  endfunction

  // Reference memory: one word array per instance plus per-byte "written" flags.
  logic [15:0] mdl    [4][1024];
  logic [1:0]  mvalid [4][1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_exp(input int k, input logic w, input logic [31:0] a,
                           input logic [15:0] d, input logic [1:0] s,
                           output logic bad, output logic [15:0] exp_d,
                           output logic [15:0] mask);
    logic [31:0] o;
    int idx;
    o     = a - base_of(k);
    bad   = (o >= 32'd2048) || (o % 2 != 0);
    idx   = int'(o / 2);
    exp_d = '0;
    mask  = '0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < 2; i++) begin
          if (s[i]) begin
            mdl[k][idx][8*i +: 8] = d[8*i +: 8];
            mvalid[k][idx][i]     = 1'b1;
          end
        end
      end else begin
        exp_d = mdl[k][idx];
        mask  = {{8{mvalid[k][idx][1]}}, {8{mvalid[k][idx][0]}}};
      end
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [15:0] d, input logic [1:0] s,
                      output logic ga, output logic ge, output logic [15:0] gd,
                      output int n);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
    cti[k] = 3'($urandom); bte[k] = 2'($urandom);
    ga = 1'b0; ge = 1'b0; gd = '0; n = 0;
    while (n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ack[k] || err[k]) begin
        ga = ack[k]; ge = err[k]; gd = rdat[k];
        break;
      end
      check("dat_quiet", 32'(rdat[k]), 32'd0);
    end
    cyc[k] = 1'b0; stb[k] = 1'b0; wdat[k] = 16'($urandom);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  s;
    logic        exp_err;
    logic        chk_dat;
    logic [15:0] exp_dat;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [15:0] d,
                              input logic [1:0] s, input logic e, input logic c,
                              input logic [15:0] x);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.exp_err = e; v.chk_dat = c; v.exp_dat = x;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    logic ga, ge, bad;
    logic [15:0] gd, ed, mask;
    int n;
    logic [31:0] baddr[5];
    logic [15:0] bdat[5];
    logic        bwe[5];
    int ackc[5];
    int beat;

    clk = 1'b0;
    rst_n = '0; cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0;
    sel = '0; cti = '0; bte = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 1024; i++) begin
        mdl[k][i] = '0; mvalid[k][i] = '0;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("reset_ack", 32'(ack[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_dat", 32'(rdat[k]), 32'd0);
    end
    rst_n = '1;

    // Vector table on the one-wait-state instance
    tbl[0]  = mk(1, 32'h10,  16'hBEEF, 2'b11, 0, 0, 16'h0);
    tbl[1]  = mk(0, 32'h10,  16'h0,    2'b11, 0, 1, 16'hBEEF);
    tbl[2]  = mk(1, 32'h20,  16'h1234, 2'b11, 0, 0, 16'h0);
    tbl[3]  = mk(1, 32'h20,  16'hAB00, 2'b10, 0, 0, 16'h0);
    tbl[4]  = mk(0, 32'h20,  16'h0,    2'b01, 0, 1, 16'hAB34);
    tbl[5]  = mk(1, 32'h00,  16'h5A5A, 2'b11, 0, 0, 16'h0);
    tbl[6]  = mk(0, 32'h800, 16'h0,    2'b11, 1, 1, 16'h0);
    tbl[7]  = mk(1, 32'h801, 16'hC3C3, 2'b11, 1, 0, 16'h0);
    tbl[8]  = mk(0, 32'h00,  16'h0,    2'b11, 0, 1, 16'h5A5A);
    tbl[9]  = mk(1, 32'h7FE, 16'h0F0F, 2'b11, 0, 0, 16'h0);
    tbl[10] = mk(0, 32'h7FE, 16'h0,    2'b11, 0, 1, 16'h0F0F);
    tbl[11] = mk(1, 32'hFFFF_FFFE, 16'h1111, 2'b11, 1, 0, 16'h0);
    tbl[12] = mk(0, 32'h001, 16'h0,    2'b11, 1, 1, 16'h0);
    tbl[13] = mk(0, 32'h00,  16'h0,    2'b11, 0, 1, 16'h5A5A);
    for (int i = 0; i < 14; i++) begin
      xfer(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, ga, ge, gd, n);
      model_exp(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, bad, ed, mask);
      check("tbl_ack", 32'(ga), 32'(!tbl[i].exp_err));
      check("tbl_err", 32'(ge), 32'(tbl[i].exp_err));
      check("tbl_latency", 32'(n), 32'd2);
      if (tbl[i].chk_dat) check("tbl_dat", 32'(gd), 32'(tbl[i].exp_dat));
    end

    // Back-to-back with stb held, zero wait states; last beat reads back the
    // previous write in the IDLE cycle right after its RESP.
    for (int i = 0; i < 4; i++) begin
      baddr[i] = 32'h40 + 32'(2 * i);
      bdat[i]  = 16'h1001 * 16'(i + 1);
      bwe[i]   = 1'b1;
    end
    baddr[4] = 32'h46; bdat[4] = 16'h0; bwe[4] = 1'b0;
    beat = 0;
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; sel[0] = 2'b11;
    we[0] = bwe[0]; addr[0] = baddr[0]; wdat[0] = bdat[0];
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[0] || err[0]) begin
        if (beat < 5) begin
          ackc[beat] = c;
          if (!bwe[beat]) check("b2b_raw_dat", 32'(rdat[0]), 32'h4004);
        end
        beat++;
        if (beat >= 5) begin
          cyc[0] = 1'b0; stb[0] = 1'b0;
        end else begin
          we[0] = bwe[beat]; addr[0] = baddr[beat]; wdat[0] = bdat[beat];
        end
      end
    end
    check("b2b_count", 32'(beat), 32'd5);
    check("b2b_first", 32'(ackc[0]), 32'd0);
    for (int i = 1; i < 5; i++) check("b2b_spacing", 32'(ackc[i] - ackc[i-1]), 32'd2);
    for (int i = 0; i < 4; i++) model_exp(0, 1'b1, baddr[i], bdat[i], 2'b11, bad, ed, mask);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, baddr[i], 16'h0, 2'b11, ga, ge, gd, n);
      check("b2b_readback", 32'(gd), 32'(bdat[i]));
    end

    // Abort: WAIT_STATES=3, request dropped in the last wait cycle
    xfer(2, 1'b1, 32'h8030, 16'h1111, 2'b11, ga, ge, gd, n);
    model_exp(2, 1'b1, 32'h8030, 16'h1111, 2'b11, bad, ed, mask);
    check("abort_pre_ack", 32'(ga), 32'd1);
    check("abort_pre_latency", 32'(n), 32'd4);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h8030;
    wdat[2] = 16'h2222; sel[2] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_resp", 32'({ack[2], err[2]}), 32'd0);
    end
    cyc[2] = 1'b0;
    xfer(2, 1'b0, 32'h8030, 16'h0, 2'b11, ga, ge, gd, n);
    check("abort_readback", 32'(gd), 32'h1111);

    // Reset mid-WAIT and reset on the edge that would enter RESP
    xfer(3, 1'b1, 32'h8050, 16'h7777, 2'b11, ga, ge, gd, n);
    xfer(3, 1'b1, 32'h8052, 16'hAAAA, 2'b11, ga, ge, gd, n);
    model_exp(3, 1'b1, 32'h8050, 16'h7777, 2'b11, bad, ed, mask);
    model_exp(3, 1'b1, 32'h8052, 16'hAAAA, 2'b11, bad, ed, mask);
    check("rst_pre_latency", 32'(n), 32'd6);
    @(negedge clk);
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h8050;
    wdat[3] = 16'h9999; sel[3] = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[3] = 1'b0; cyc[3] = 1'b0; stb[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_outs", 32'({ack[3], err[3], rdat[3]}), 32'd0);
    rst_n[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_wait_quiet", 32'({ack[3], err[3]}), 32'd0);
    end
    xfer(3, 1'b0, 32'h8050, 16'h0, 2'b11, ga, ge, gd, n);
    check("rst_wait_readback", 32'(gd), 32'h7777);
    check("rst_idle_latency", 32'(n), 32'd6);
    @(negedge clk);
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h8052;
    wdat[3] = 16'h5555; sel[3] = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_outs", 32'({ack[3], err[3]}), 32'd0);
    rst_n[3] = 1'b1; cyc[3] = 1'b0; stb[3] = 1'b0;
    xfer(3, 1'b0, 32'h8052, 16'h0, 2'b11, ga, ge, gd, n);
    check("rst_resp_readback", 32'(gd), 32'hAAAA);

    // Randomized traffic against the reference memory on every instance
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 60; t++) begin
        logic [31:0] a;
        logic w;
        logic [1:0] s;
        logic [15:0] d;
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = base_of(k) + 32'd2048 + 32'(2 * $urandom_range(0, 100));
        else if (r == 1) a = base_of(k) + 32'(2 * $urandom_range(0, 31)) + 32'd1;
        else if (r == 2) a = base_of(k) - 32'd2;
        else             a = base_of(k) + 32'(2 * $urandom_range(0, 31));
        w = 1'($urandom);
        s = 2'($urandom);
        d = 16'($urandom);
        xfer(k, w, a, d, s, ga, ge, gd, n);
        model_exp(k, w, a, d, s, bad, ed, mask);
        check("rand_ack", 32'(ga), 32'(!bad));
        check("rand_err", 32'(ge), 32'(bad));
        check("rand_latency", 32'(n), 32'(ws_of(k) + 1));
        if (bad)     check("rand_err_dat", 32'(gd), 32'd0);
        else if (!w) check("rand_rdat", 32'(gd & mask), 32'(ed & mask));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/osd_mam_wb_sram.md
Name: osd_mam_wb_sram

Overview:
- Wishbone classic slave memory directly downstream of the MAM Wishbone master interface.
- Consumes the single-beat cycles that master produces (stb/cyc, we, addr, sel, dat) and returns ack/err with read data.
- Provides a configurable wait-state count so the master's wait and back-to-back paths can be exercised.
- Serves as the on-chip debug scratch memory in MAM subsystems and as the standard bench target for the MAM.

Parameters:
- DATA_WIDTH, 16: bus width in bits; legal values 8, 16, 32. SW = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- MEM_WORDS, 1024: depth in DATA_WIDTH words; power of two, at least 2.
- BASE_ADDR, 0: byte address of word 0; must be aligned to MEM_WORDS*SW.
- WAIT_STATES, 1: extra cycles between accepting a request and ack/err; range 0..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- cyc_i  in  1  bus cycle active
- stb_i  in  1  transfer strobe
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  byte address
- dat_i  in  DATA_WIDTH  write data
- sel_i  in  SW  byte lane enables
- cti_i  in  3  cycle type; only 3'b000 is supported, other values are treated as 000
- bte_i  in  2  burst type; ignored
- ack_o  out  1  normal termination, one-cycle pulse
- err_o  out  1  error termination, one-cycle pulse
- dat_o  out  DATA_WIDTH  read data, valid only while ack_o=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: state=IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0. Memory contents are not reset.
- A request is present when cyc_i & stb_i = 1.
- Decode is evaluated at acceptance:
  - off = addr_i - BASE_ADDR, computed at ADDR_WIDTH bits with wrap.
  - Request is in range when off < MEM_WORDS*SW.
  - Request is aligned when off[log2(SW)-1:0] = 0; DATA_WIDTH=8 is always aligned.
  - Word index = off >> log2(SW).
  - bad = !in_range | !aligned.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If a request is present, latch we_i, index, dat_i, sel_i and bad.
  - If WAIT_STATES=0, go to RESP; otherwise load cnt = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If the request has dropped (cyc_i=0 or stb_i=0), abort: go to IDLE with no ack, no err and no memory write.
  - Else, if cnt=0, go to RESP; otherwise decrement cnt.
- RESP, one cycle:
  - If !bad: ack_o=1. A write updates each byte lane i where the latched sel[i]=1. A read drives dat_o with the memory word at the latched index; lanes with sel=0 are still driven.
  - If bad: err_o=1, dat_o=0, no memory write.
  - Always go to IDLE next.
- Response outputs:
  - ack_o, err_o and dat_o are registered outputs, asserted exactly during the RESP cycle and 0 otherwise.
  - ack_o and err_o are never both 1.
- Latency: a request accepted in cycle t responds in cycle t+1+WAIT_STATES.
- Back-to-back:
  - A request still present in the RESP cycle is ignored; the master advances address/data on ack.
  - A request present in the following IDLE cycle is a new transfer.
  - Minimum spacing is therefore 2+WAIT_STATES cycles per beat.
- Read-after-write: a read accepted in the IDLE cycle after a write's RESP returns the new data.
- Write-data sampling: write data and sel are sampled at acceptance; changes to dat_i during WAIT are ignored.
- Reset mid-operation: rst_ni=0 in WAIT or RESP returns to IDLE with outputs 0 in the next cycle. A write whose RESP edge coincides with the reset edge is not committed.
- Memory: one read/write port, inferrable as block RAM with byte enables; no combinational path from inputs to outputs.

Test Plan:
- Reset, WAIT_STATES=1, DATA_WIDTH=16: write addr 0x10, dat 0xBEEF, sel 2'b11 -> ack_o pulse 2 cycles after acceptance; then read 0x10 -> ack_o with dat_o=0xBEEF.
- Byte enables: write 0x20 = 0x1234 (sel 11), then 0xAB00 (sel 10); read 0x20 -> dat_o=0xAB34.
- Out of range and misaligned, MEM_WORDS=1024, BASE_ADDR=0: read 0x800 -> err_o=1, ack_o=0, dat_o=0; write 0x801 -> err_o=1 and a read of word 0x400>>... is not performed; word 0x000 unchanged.
- Abort: WAIT_STATES=3, stb_i dropped after 2 cycles of a write to 0x30 -> no ack/err; reading 0x30 returns the prior value.
- Back-to-back, WAIT_STATES=0: the MAM master issues a 4-beat write 0x40..0x46 with stb held high -> exactly 4 ack pulses spaced 2 cycles apart; readback gives data in order.
- Reset mid-WAIT: WAIT_STATES=5, rst_ni=0 for 1 cycle during WAIT -> next cycle state=IDLE, ack_o=err_o=0, target word unchanged.
